// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end sharing one iterative shift-add multiplier.
// One multiplier bit is consumed per CALC cycle; results are held until accepted.
module mult_arbiter #(
    parameter int N = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0_valid,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*N-1:0]   rsp_product,
    output logic             busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   acc_next;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [2*N-1:0]   rsp_prod_q, rsp_prod_d;
    logic             busy_q, busy_d;
    logic             gnt0, gnt1;

    // last_q holds the index granted most recently; a tie goes to the other one.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RST && state_q == S_IDLE) begin
            if (req0_valid && (!req1_valid || last_q)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign acc_next = b_q[0] ? (acc_q + a_q) : acc_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d     = {{N{1'b0}}, (gnt1 ? req1_a : req0_a)};
                    b_d     = gnt1 ? req1_b : req0_b;
                    id_d    = gnt1;
                    last_d  = gnt1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = acc_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                // Result is registered on the final CALC edge so it is valid on entry to DONE.
                if (cnt_q == CW'(N - 1)) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_prod_d  = acc_next;
                    rsp_id_d    = id_q;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_prod_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_prod_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_mult_arbiter;

    localparam int N = 8;

    logic           CLK = 1'b0;
    logic           RST;
    logic           req0_valid, req1_valid;
    logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           req0_ready, req1_ready;
    logic           rsp_valid, rsp_ready, rsp_id, busy;
    logic [2*N-1:0] rsp_product;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mult_arbiter #(.N(N)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_product(rsp_product),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 multiplying, 2 result waiting for consumer.
    int             m_phase = 0;
    int             m_timer = 0;
    bit             m_last  = 1'b1;
    bit             m_pid   = 1'b0;
    logic [2*N-1:0] m_pprod = '0;
    logic [2*N-1:0] m_prod  = '0;
    bit             m_id    = 1'b0;
    bit             m_valid = 1'b0;

    function automatic bit m_gnt(input int r);
        if (RST !== 1'b1 || m_phase != 0) return 1'b0;
        if (r == 0) return req0_valid && (!req1_valid || m_last);
        return req1_valid && (!req0_valid || !m_last);
    endfunction

    always @(posedge CLK) begin
        if (RST !== 1'b1) begin
            m_phase <= 0;
            m_timer <= 0;
            m_valid <= 1'b0;
            m_prod  <= '0;
            m_id    <= 1'b0;
            m_last  <= 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    if (m_gnt(0)) begin
                        m_pid   <= 1'b0;
                        m_pprod <= (2*N)'(req0_a) * (2*N)'(req0_b);
                        m_last  <= 1'b0;
                        m_timer <= 0;
                        m_phase <= 1;
                    end else if (m_gnt(1)) begin
                        m_pid   <= 1'b1;
                        m_pprod <= (2*N)'(req1_a) * (2*N)'(req1_b);
                        m_last  <= 1'b1;
                        m_timer <= 0;
                        m_phase <= 1;
                    end
                end
                1: begin
                    m_timer <= m_timer + 1;
                    if (m_timer + 1 == N) begin
                        m_phase <= 2;
                        m_valid <= 1'b1;
                        m_prod  <= m_pprod;
                        m_id    <= m_pid;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        m_phase <= 0;
                        m_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_req0_ready", req0_ready, m_gnt(0));
            chk("m_req1_ready", req1_ready, m_gnt(1));
            chk("m_rsp_valid", rsp_valid, m_valid);
            chk("m_busy", busy, (m_phase != 0));
            chk("m_rsp_id", rsp_id, m_id);
            chk("m_rsp_product", rsp_product, m_prod);
        end
    end

    // Drive one request until accepted; returns aligned just after the acceptance edge.
    task automatic do_req(input int r, input logic [N-1:0] a, input logic [N-1:0] b);
        bit got = 1'b0;
        if (r == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            got = (r == 0) ? req0_ready : req1_ready;
            @(posedge CLK); #1;
        end
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk("accept_timeout", got, 1'b1);
    endtask

    // Wait for a response; lat counts edges from acceptance through the handshake edge.
    task automatic wait_rsp(input bit disturb, output bit id, output logic [2*N-1:0] prod,
                            output int lat);
        bit seen = 1'b0;
        lat  = 0;
        id   = 1'b0;
        prod = '0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                seen = 1'b1;
                id   = rsp_id;
                prod = rsp_product;
            end
            @(posedge CLK); #1;
            lat++;
            if (disturb) begin
                req0_a = N'($urandom);
                req0_b = N'($urandom);
            end
        end
        chk("rsp_timeout", seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit             id;
        logic [2*N-1:0] prod;
        int             lat;
        bit             seen;
        bit             ids[4];
        logic [2*N-1:0] prods[4];

        RST = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(posedge CLK); #1;
        chk_en = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_product", rsp_product, 16'h0000);
        chk("rst_rsp_id", rsp_id, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge CLK); #1;

        // Single request
        do_req(0, 8'h0D, 8'h0B);
        wait_rsp(1'b0, id, prod, lat);
        chk("single_latency", lat, N + 1);
        chk("single_product", prod, 16'h008F);
        chk("single_id", id, 1'b0);
        @(negedge CLK);
        chk("hold_valid_low", rsp_valid, 1'b0);
        chk("hold_product", rsp_product, 16'h008F);
        @(posedge CLK); #1;

        // Max and zero operands
        do_req(1, 8'hFF, 8'hFF);
        wait_rsp(1'b0, id, prod, lat);
        chk("max_product", prod, 16'hFE01);
        chk("max_id", id, 1'b1);
        do_req(1, 8'h00, 8'hA5);
        wait_rsp(1'b0, id, prod, lat);
        chk("zero_product", prod, 16'h0000);
        chk("zero_latency", lat, N + 1);

        // Tie after reset: round robin starting with requester 0
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        req0_a = 8'd3; req0_b = 8'd5; req1_a = 8'd7; req1_b = 8'd9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(1'b0, ids[k], prods[k], lat);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie_id0", ids[0], 1'b0);
        chk("tie_prod0", prods[0], 16'd15);
        chk("tie_id1", ids[1], 1'b1);
        chk("tie_prod1", prods[1], 16'd63);
        chk("tie_id2", ids[2], 1'b0);
        chk("tie_id3", ids[3], 1'b1);
        chk("tie_prod3", prods[3], 16'd63);

        // Backpressure with a competing requester waiting
        rsp_ready = 1'b0;
        do_req(0, 8'h21, 8'h04);
        req1_valid = 1'b1; req1_a = 8'd1; req1_b = 8'd1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            if (rsp_valid) seen = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        chk("bp_seen", seen, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_product", rsp_product, 16'h0084);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_req0_ready", req0_ready, 1'b0);
            chk("bp_req1_ready", req1_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
        end
        @(posedge CLK); #1;
        rsp_ready = 1'b1; req1_valid = 1'b0;
        @(negedge CLK);
        chk("bp_still_valid", rsp_valid, 1'b1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("bp_idle_busy", busy, 1'b0);
        chk("bp_idle_valid", rsp_valid, 1'b0);
        @(posedge CLK); #1;

        // Reset in the middle of CALC
        do_req(0, 8'h55, 8'h33);
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", rsp_valid, 1'b0);
        chk("abort_product", rsp_product, 16'h0000);
        @(posedge CLK); #1;
        do_req(0, 8'd2, 8'd3);
        wait_rsp(1'b0, id, prod, lat);
        chk("after_abort_product", prod, 16'h0006);

        // Operand disturbance while multiplying
        do_req(0, 8'hC3, 8'h5A);
        wait_rsp(1'b1, id, prod, lat);
        chk("disturb_product", prod, 16'h448E);
        chk("disturb_id", id, 1'b0);

        repeat (3) @(posedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
